rv_trace_fmt: RTL and testbench

- Streaming RISC-V retirement-trace formatter: accepts one retired instruction (pc, op) per handshake and emits its disassembly as an ASCII byte stream, one character per cycle, terminated by '\n'.
- Sits between the core's retire port and the trace sink (UART/DPI byte consumer).
- Successor to the string-based combinational disassembly helpers. Adds parametrised XLEN, runtime ABI/numeric register naming, valid/ready backpressure on both sides, and a line counter.

---
 rtl/rv_trace_fmt.sv | 226 ++++++++++++++++++++++
 tb/tb_rv_trace_fmt.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_trace_fmt.sv
// Retirement-trace formatter: turns one (pc, op) into "<pc hex>: <disasm>\n", one ASCII byte per cycle.
// Latency: first character is valid one cycle after accept; the line is finished when '\n' is handshaked.
// Backpressure: accepts only in IDLE; a stalled sink freezes all state, so out_char/out_last hold stable.
module rv_trace_fmt #(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 16,
    parameter bit ABI_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_op,
    input  logic             abi_en,
    input  logic             abi_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last,
    output logic [CNT_W-1:0] line_count
);
    localparam int NDIG = XLEN / 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    // Segments of a line, emitted in this order; non-jalr lines jump from WORD to NL.
    localparam logic [3:0] SEG_PC    = 4'd0;
    localparam logic [3:0] SEG_SEP   = 4'd1;
    localparam logic [3:0] SEG_WORD  = 4'd2;
    localparam logic [3:0] SEG_RD    = 4'd3;
    localparam logic [3:0] SEG_MID   = 4'd4;
    localparam logic [3:0] SEG_IMM   = 4'd5;
    localparam logic [3:0] SEG_OPEN  = 4'd6;
    localparam logic [3:0] SEG_RS1   = 4'd7;
    localparam logic [3:0] SEG_CLOSE = 4'd8;
    localparam logic [3:0] SEG_NL    = 4'd9;

    localparam logic [1:0] K_NOP  = 2'd0;
    localparam logic [1:0] K_DASH = 2'd1;
    localparam logic [1:0] K_JALR = 2'd2;
    localparam logic [1:0] K_ILL  = 2'd3;

    function automatic logic [7:0] dig(input logic [4:0] v);
        return 8'h30 + {3'b000, v};
    endfunction

    function automatic logic [7:0] hex_chr(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h57 + {4'h0, d});
    endfunction

    // Returns {length-1, name left-aligned in 5 chars, space padded}.
    function automatic logic [42:0] reg_name(input logic [4:0] r, input logic abi);
        logic [39:0] n;
        logic [2:0]  l;
        n = "     ";
        l = 3'd1;
        if (abi) begin
            case (r)
                5'd0:    begin n = "zero "; l = 3'd3; end
                5'd1:    n = "ra   ";
                5'd2:    n = "sp   ";
                5'd3:    n = "gp   ";
                5'd4:    n = "tp   ";
                5'd8:    begin n = "s0/fp"; l = 3'd4; end
                5'd9:    n = "s1   ";
                default: begin
                    if (r <= 5'd7)       n = {"t", dig(r - 5'd5), "   "};
                    else if (r <= 5'd17) n = {"a", dig(r - 5'd10), "   "};
                    else if (r <= 5'd25) n = {"s", dig(r - 5'd16), "   "};
                    else if (r <= 5'd27) begin n = {"s1", dig(r - 5'd26), "  "}; l = 3'd2; end
                    else                 n = {"t", dig(r - 5'd25), "   "};
                end
            endcase
        end else begin
            if (r < 5'd10)      n = {"x", dig(r), "   "};
            else if (r < 5'd20) begin n = {"x1", dig(r - 5'd10), "  "}; l = 3'd2; end
            else if (r < 5'd30) begin n = {"x2", dig(r - 5'd20), "  "}; l = 3'd2; end
            else                begin n = {"x3", dig(r - 5'd30), "  "}; l = 3'd2; end
        end
        return {l, n};
    endfunction

    logic [0:0]       state_q, state_d;
    logic [3:0]       seg_q, seg_d;
    logic [3:0]       idx_q, idx_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [4:0]       rd_q, rd_d, rs1_q, rs1_d;
    logic [11:0]      imm_q, imm_d;
    logic             abi_q, abi_d;
    logic [1:0]       kind_q, kind_d;
    logic [CNT_W-1:0] line_q, line_d;

    logic [1:0]       kind_in;
    logic [42:0]      rd_nm, rs1_nm;
    logic [3:0]       seg_max, seg_nxt, dsel;
    logic [XLEN-1:0]  pc_sh;
    logic [55:0]      word, word_sh;
    logic [39:0]      nm_sh;
    logic [31:0]      mid_sh;
    logic [11:0]      imm_sh;
    logic [7:0]       ch;
    logic             last;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = (state_q == EMIT);
    assign out_char   = (state_q == EMIT) ? ch : 8'h00;
    assign out_last   = (state_q == EMIT) && last;
    assign line_count = line_q;

    // Classify the incoming instruction once, at accept time.
    always_comb begin
        kind_in = K_ILL;
        if (in_op == 32'h0000_0013)                           kind_in = K_NOP;
        else if (in_op == 32'h0000_4033)                      kind_in = K_DASH;
        else if (in_op[6:0] == 7'b1100111 && in_op[14:12] == 3'b000) kind_in = K_JALR;
    end

    // Character generator: pick the byte for (segment, index) and the segment's last index.
    always_comb begin
        rd_nm   = reg_name(rd_q, abi_q);
        rs1_nm  = reg_name(rs1_q, abi_q);
        dsel    = 4'(NDIG - 1) - idx_q;
        pc_sh   = pc_q >> {dsel, 2'b00};
        case (kind_q)
            K_NOP:   word = "nop    ";
            K_DASH:  word = "-      ";
            K_JALR:  word = "jalr   ";
            default: word = "illegal";
        endcase
        word_sh = word << {idx_q, 3'b000};
        nm_sh   = (seg_q == SEG_RD ? rd_nm[39:0] : rs1_nm[39:0]) << {idx_q, 3'b000};
        mid_sh  = 32'(", 0x") << {idx_q, 3'b000};
        imm_sh  = imm_q << {idx_q, 2'b00};
        ch      = 8'h00;
        last    = 1'b0;
        seg_max = 4'd0;
        seg_nxt = seg_q + 4'd1;
        case (seg_q)
            SEG_PC:    begin ch = hex_chr(pc_sh[3:0]); seg_max = 4'(NDIG - 1); end
            SEG_SEP:   begin ch = (idx_q == 4'd0) ? ":" : " "; seg_max = 4'd1; end
            SEG_WORD:  begin
                ch = word_sh[55:48];
                case (kind_q)
                    K_NOP:   seg_max = 4'd2;
                    K_DASH:  seg_max = 4'd0;
                    K_JALR:  seg_max = 4'd5;
                    default: seg_max = 4'd6;
                endcase
                seg_nxt = (kind_q == K_JALR) ? SEG_RD : SEG_NL;
            end
            SEG_RD:    begin ch = nm_sh[39:32]; seg_max = {1'b0, rd_nm[42:40]}; end
            SEG_MID:   begin ch = mid_sh[31:24]; seg_max = 4'd3; end
            SEG_IMM:   begin ch = hex_chr(imm_sh[11:8]); seg_max = 4'd2; end
            SEG_OPEN:  begin ch = (idx_q == 4'd0) ? " " : "("; seg_max = 4'd1; end
            SEG_RS1:   begin ch = nm_sh[39:32]; seg_max = {1'b0, rs1_nm[42:40]}; end
            SEG_CLOSE: ch = ")";
            default:   begin ch = 8'h0a; last = 1'b1; end
        endcase
    end

    // Next state: capture in IDLE, walk segment/index on each output handshake.
    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        idx_d   = idx_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        imm_d   = imm_q;
        abi_d   = abi_q;
        kind_d  = kind_q;
        line_d  = line_q;
        if (state_q == IDLE) begin
            if (in_valid && in_ready) begin
                state_d = EMIT;
                seg_d   = SEG_PC;
                idx_d   = 4'd0;
                pc_d    = in_pc;
                rd_d    = in_op[11:7];
                rs1_d   = in_op[19:15];
                imm_d   = in_op[31:20];
                abi_d   = abi_en ? abi_sel : ABI_DEFAULT;
                kind_d  = kind_in;
            end
        end else if (out_ready) begin
            if (last) begin
                state_d = IDLE;
                line_d  = line_q + 1'b1;
            end else if (idx_q == seg_max) begin
                seg_d = seg_nxt;
                idx_d = 4'd0;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    // State registers; reset drops any line in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            seg_q   <= SEG_PC;
            idx_q   <= 4'd0;
            pc_q    <= '0;
            rd_q    <= 5'd0;
            rs1_q   <= 5'd0;
            imm_q   <= 12'd0;
            abi_q   <= 1'b0;
            kind_q  <= K_NOP;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            idx_q   <= idx_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            imm_q   <= imm_d;
            abi_q   <= abi_d;
            kind_q  <= kind_d;
            line_q  <= line_d;
        end
    end
endmodule

// File: tb/tb_rv_trace_fmt.sv
// Bench for rv_trace_fmt: a 32-bit instance (2-bit line counter) and a 64-bit instance.
// Expected bytes are queued when an instruction is offered and popped on each output handshake.
// Random out_ready exercises backpressure; stalled cycles must hold out_char/out_last.
module tb_rv_trace_fmt;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, abi_en, abi_sel, out_ready, use64;
    logic [63:0] in_pc;
    logic [31:0] in_op;

    logic        in_ready_a, out_valid_a, out_last_a;
    logic [7:0]  out_char_a;
    logic [1:0]  lc_a;
    logic        in_ready_b, out_valid_b, out_last_b;
    logic [7:0]  out_char_b;
    logic [15:0] lc_b;

    rv_trace_fmt #(.XLEN(32), .CNT_W(2), .ABI_DEFAULT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid && !use64), .in_ready(in_ready_a),
        .in_pc(in_pc[31:0]), .in_op(in_op), .abi_en(abi_en), .abi_sel(abi_sel),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_char(out_char_a),
        .out_last(out_last_a), .line_count(lc_a));

    rv_trace_fmt #(.XLEN(64), .CNT_W(16), .ABI_DEFAULT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid && use64), .in_ready(in_ready_b),
        .in_pc(in_pc), .in_op(in_op), .abi_en(abi_en), .abi_sel(abi_sel),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_char(out_char_b),
        .out_last(out_last_b), .line_count(lc_b));

    wire        m_in_ready  = use64 ? in_ready_b  : in_ready_a;
    wire        m_out_valid = use64 ? out_valid_b : out_valid_a;
    wire        m_out_last  = use64 ? out_last_b  : out_last_a;
    wire [7:0]  m_out_char  = use64 ? out_char_b  : out_char_a;
    wire [15:0] m_lc        = use64 ? lc_b : {14'd0, lc_a};

    int         total = 0;
    int         bad = 0;
    int         lc_m_a = 0;
    int         lc_m_b = 0;
    logic [7:0] exp_q[$];

    // Offer one instruction and drain its line. limit>0 stops after that many bytes.
    task automatic run_line(input logic [63:0] pc, input logic [31:0] op, input logic ae,
                            input logic as, input string txt, input bit stall, input int limit);
        string      s;
        int         n, cyc, exp_lc;
        bit         done, pst, saw_last;
        logic [7:0] pch, e;
        logic       plast;
        if (use64) s = $sformatf("%016h: %s\n", pc, txt);
        else       s = $sformatf("%08h: %s\n", pc[31:0], txt);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        @(negedge clk);
        total++;
        if (m_in_ready !== 1'b1) begin bad++; $display("FAIL in_ready_idle got=%b want=1", m_in_ready); end
        in_valid = 1'b1; in_pc = pc; in_op = op; abi_en = ae; abi_sel = as;
        @(posedge clk); #1;
        in_valid = 1'b0; in_pc = {$urandom, $urandom}; in_op = $urandom;
        abi_en = ~ae; abi_sel = ~as;
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        n = 0; cyc = 0; done = 0; pst = 0; saw_last = 0; pch = 8'h00; plast = 1'b0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                total++;
                if (m_out_valid !== 1'b1) begin bad++; $display("FAIL latency out_valid got=%b want=1", m_out_valid); end
            end
            if (m_out_valid === 1'b1) begin
                total++;
                if (m_in_ready !== 1'b0) begin bad++; $display("FAIL in_ready_emit got=%b want=0", m_in_ready); end
                if (pst) begin
                    total++;
                    if (m_out_char !== pch || m_out_last !== plast) begin
                        bad++;
                        $display("FAIL stall_hold got=%h/%b want=%h/%b", m_out_char, m_out_last, pch, plast);
                    end
                end
                if (out_ready) begin
                    pst = 0;
                    n++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++; $display("FAIL extra_char got=%h want=none", m_out_char); done = 1;
                    end else begin
                        e = exp_q.pop_front();
                        if (m_out_char !== e) begin bad++; $display("FAIL char[%0d] got=%h want=%h", n - 1, m_out_char, e); end
                        total++;
                        if (m_out_last !== (e == 8'h0a)) begin bad++; $display("FAIL last[%0d] got=%b want=%b", n - 1, m_out_last, e == 8'h0a); end
                        if (e == 8'h0a) begin saw_last = 1; done = 1; end
                        if (limit > 0 && n == limit) done = 1;
                    end
                end else begin
                    pst = 1; pch = m_out_char; plast = m_out_last;
                end
            end
            if (cyc > 300) begin
                bad++; $display("FAIL timeout got=%0d chars want=%0d", n, s.len()); done = 1;
            end
            if (!done) begin
                @(posedge clk); #1;
                out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        if (saw_last) begin
            if (!stall) begin
                total++;
                if (cyc != s.len()) begin bad++; $display("FAIL line_cycles got=%0d want=%0d", cyc, s.len()); end
            end
            @(posedge clk); #1;
            if (use64) begin lc_m_b = (lc_m_b + 1) % 65536; exp_lc = lc_m_b; end
            else       begin lc_m_a = (lc_m_a + 1) % 4;     exp_lc = lc_m_a; end
            total++;
            if (m_lc !== 16'(exp_lc)) begin bad++; $display("FAIL line_count got=%0d want=%0d", m_lc, exp_lc); end
            total++;
            if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
                bad++; $display("FAIL idle_after_line got=%b/%b want=0/1", m_out_valid, m_in_ready);
            end
        end
    endtask

    task automatic test_reset();
        use64 = 1'b0; rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_pc = 64'h100; in_op = 32'h13; abi_en = 1'b0; abi_sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b%b want=00", in_ready_a, in_ready_b); end
        total++;
        if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b%b want=00", out_valid_a, out_valid_b); end
        total++;
        if (out_char_a !== 8'h00 || out_last_a !== 1'b0) begin bad++; $display("FAIL rst_out_char got=%h/%b want=00/0", out_char_a, out_last_a); end
        total++;
        if (lc_a !== 2'd0 || lc_b !== 16'd0) begin bad++; $display("FAIL rst_line_count got=%0d/%0d want=0/0", lc_a, lc_b); end
        in_valid = 1'b0; rst = 1'b0;
        #1;
        total++;
        if (in_ready_a !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%b want=1", in_ready_a); end
        @(negedge clk);
        total++;
        if (out_valid_a !== 1'b0) begin bad++; $display("FAIL rst_vs_handshake got=%b want=0", out_valid_a); end
    endtask

    task automatic test_nop();
        use64 = 1'b0;
        run_line(64'h100, 32'h0000_0013, 1'b0, 1'b0, "nop", 1'b0, 0);
    endtask

    task automatic test_jalr_modes();
        use64 = 1'b0;
        run_line(64'h8000_0004, 32'h0102_80E7, 1'b1, 1'b1, "jalr  ra, 0x010 (t0)", 1'b0, 0);
        run_line(64'h8000_0004, 32'h0102_80E7, 1'b0, 1'b1, "jalr  x1, 0x010 (x5)", 1'b0, 0);
        run_line(64'h1234_abcd, 32'hABC5_0FE7, 1'b1, 1'b0, "jalr  x31, 0xabc (x10)", 1'b0, 0);
        run_line(64'h1234_abcd, 32'hABC5_0FE7, 1'b1, 1'b1, "jalr  t6, 0xabc (a0)", 1'b0, 0);
    endtask

    task automatic test_abi_cover();
        use64 = 1'b0;
        run_line(64'h0000_0040, 32'h0000_0467, 1'b1, 1'b1, "jalr  s0/fp, 0x000 (zero)", 1'b0, 0);
        run_line(64'h0000_0044, 32'hFFFD_0D67, 1'b1, 1'b1, "jalr  s10, 0xfff (s10)", 1'b0, 0);
    endtask

    task automatic test_decode_edges();
        use64 = 1'b0;
        run_line(64'hdead_beef, 32'hFFFF_FFFF, 1'b0, 1'b0, "illegal", 1'b0, 0);
        run_line(64'h0000_0008, 32'h0000_4033, 1'b0, 1'b0, "-", 1'b0, 0);
        run_line(64'h0000_000c, 32'h0000_10E7, 1'b0, 1'b0, "illegal", 1'b0, 0);
    endtask

    task automatic test_xlen64();
        use64 = 1'b1;
        run_line(64'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, "illegal", 1'b0, 0);
        run_line(64'hfedc_ba98_7654_3210, 32'h0102_80E7, 1'b1, 1'b1, "jalr  ra, 0x010 (t0)", 1'b1, 0);
        use64 = 1'b0;
    endtask

    task automatic test_backpressure();
        use64 = 1'b0;
        for (int k = 0; k < 3; k++)
            run_line(64'h8000_0004, 32'h0102_80E7, 1'b1, 1'b1, "jalr  ra, 0x010 (t0)", 1'b1, 0);
    endtask

    task automatic test_reset_mid();
        use64 = 1'b0;
        run_line(64'h8000_0004, 32'h0102_80E7, 1'b1, 1'b1, "jalr  ra, 0x010 (t0)", 1'b0, 5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready_a !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready got=%b want=0", in_ready_a); end
        @(posedge clk); #1;
        total++;
        if (out_valid_a !== 1'b0 || out_char_a !== 8'h00) begin bad++; $display("FAIL mid_rst_out got=%b/%h want=0/00", out_valid_a, out_char_a); end
        total++;
        if (lc_a !== 2'd0) begin bad++; $display("FAIL mid_rst_line_count got=%0d want=0", lc_a); end
        rst = 1'b0;
        lc_m_a = 0;
        exp_q.delete();
        #1;
        total++;
        if (in_ready_a !== 1'b1) begin bad++; $display("FAIL mid_rst_release got=%b want=1", in_ready_a); end
        run_line(64'h0000_2000, 32'h0000_0467, 1'b1, 1'b0, "jalr  x8, 0x000 (x0)", 1'b0, 0);
        run_line(64'h0000_2004, 32'h0000_0013, 1'b0, 1'b0, "nop", 1'b1, 0);
        run_line(64'h0000_2008, 32'h0000_4033, 1'b0, 1'b0, "-", 1'b0, 0);
        run_line(64'h0000_200c, 32'h1234_5678, 1'b0, 1'b0, "illegal", 1'b0, 0);
        run_line(64'h0000_2010, 32'h0102_80E7, 1'b0, 1'b0, "jalr  x1, 0x010 (x5)", 1'b1, 0);
        total++;
        if (lc_a !== 2'd1) begin bad++; $display("FAIL wrap_count got=%0d want=1", lc_a); end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_jalr_modes();
        test_abi_cover();
        test_decode_edges();
        test_xlen64();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
